// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the pipeline MEM stage and an external
// loader/debug master. The pipeline has priority; starvation and burst limits keep both sides moving.
module dmem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 8,
  parameter int BURST_MAX    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p_req,
  input  logic              p_we,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic [DATA_W-1:0] p_rdata,
  output logic              p_stall,
  input  logic              x_req,
  input  logic              x_we,
  input  logic [ADDR_W-1:0] x_addr,
  input  logic [DATA_W-1:0] x_wdata,
  output logic              x_gnt,
  output logic              x_rvalid,
  output logic [DATA_W-1:0] x_rdata,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_we,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_LIMIT);
  localparam logic [BW-1:0] BURST_TOP  = BW'(BURST_MAX);

  typedef enum logic {S_PIPE, S_EXT} own_t;

  own_t              own_q, own_d;
  logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
  logic [BW-1:0]     burst_cnt_q, burst_cnt_d;
  logic              x_rvalid_q, x_rvalid_d;
  logic [DATA_W-1:0] x_rdata_q, x_rdata_d;
  logic              grant_raw;

  assign p_rdata  = m_rdata;
  assign x_rvalid = x_rvalid_q;
  assign x_rdata  = x_rdata_q;

  always_comb begin
    grant_raw    = 1'b0;
    x_gnt        = 1'b0;
    m_addr       = p_addr;
    m_wdata      = p_wdata;
    m_we         = 1'b0;
    p_stall      = 1'b0;
    own_d        = S_PIPE;
    burst_cnt_d  = '0;
    starve_cnt_d = '0;
    x_rvalid_d   = 1'b0;
    x_rdata_d    = x_rdata_q;

    // Grant terms are gated by rst so nothing is granted or written while in reset.
    grant_raw = x_req & (~p_req | (starve_cnt_q == STARVE_TOP) |
                         ((own_q == S_EXT) & (burst_cnt_q < BURST_TOP)));
    x_gnt     = rst & grant_raw;

    if (x_gnt) begin
      m_addr  = x_addr;
      m_wdata = x_wdata;
      m_we    = x_we;
    end else begin
      m_we    = rst & p_req & p_we;
    end
    p_stall = p_req & x_gnt;

    if (x_gnt) begin
      own_d = S_EXT;
      if (own_q == S_EXT) begin
        burst_cnt_d = (burst_cnt_q < BURST_TOP) ? burst_cnt_q + 1'b1 : burst_cnt_q;
      end else begin
        burst_cnt_d = BW'(1);
      end
    end

    if (x_req & ~x_gnt) begin
      starve_cnt_d = (starve_cnt_q < STARVE_TOP) ? starve_cnt_q + 1'b1 : starve_cnt_q;
    end

    if (x_gnt & ~x_we) begin
      x_rvalid_d = 1'b1;
      x_rdata_d  = m_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      own_q        <= S_PIPE;
      starve_cnt_q <= '0;
      burst_cnt_q  <= '0;
      x_rvalid_q   <= 1'b0;
      x_rdata_q    <= '0;
    end else begin
      own_q        <= own_d;
      starve_cnt_q <= starve_cnt_d;
      burst_cnt_q  <= burst_cnt_d;
      x_rvalid_q   <= x_rvalid_d;
      x_rdata_q    <= x_rdata_d;
    end
  end

endmodule
